// File: rtl/boa_dma_copy_if.sv
// boa_mem_bus: word-addressed single-beat memory bus shared by the CPU-side initiator and its targets.
interface boa_mem_bus #(
    parameter int unsigned alen = 30
) ();
    logic [alen-1:0] addr;
    logic            re;
    logic [3:0]      we;
    logic [31:0]     wdata;
    logic            ready;
    logic [31:0]     rdata;

    modport CPU (output addr, re, we, wdata, input ready, rdata);
    modport MEM (input addr, re, we, wdata, output ready, rdata);
endinterface

// File: rtl/boa_dma_copy.sv
// Word-granular memory-to-memory copy engine: alternates one read and one write per word
// on boa_mem_bus, configured by sideband ports, with a one-cycle done pulse at the end.
module boa_dma_copy #(
    parameter int unsigned len_bits = 16
) (
    input  logic                clk,
    input  logic                rst,
    boa_mem_bus.CPU             bus,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [len_bits-1:0] len,
    output logic                busy,
    output logic                done,
    output logic [len_bits-1:0] remaining
);
    localparam int unsigned aw = $bits(bus.addr);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, FIN} state_t;

    state_t              state, state_n;
    logic [aw-1:0]       src_ptr, src_n;
    logic [aw-1:0]       dst_ptr, dst_n;
    logic [aw-1:0]       addr_q, addr_n;
    logic                re_q, re_n;
    logic [3:0]          we_q, we_n;
    logic [31:0]         data_buf, buf_n;
    logic                busy_n, done_n;
    logic [len_bits-1:0] rem_n;

    // Bus drives come straight from flops; the data buffer doubles as wdata.
    assign bus.addr  = addr_q;
    assign bus.re    = re_q;
    assign bus.we    = we_q;
    assign bus.wdata = data_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            addr_q    <= '0;
            re_q      <= 1'b0;
            we_q      <= 4'h0;
            data_buf  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_n;
            src_ptr   <= src_n;
            dst_ptr   <= dst_n;
            addr_q    <= addr_n;
            re_q      <= re_n;
            we_q      <= we_n;
            data_buf  <= buf_n;
            busy      <= busy_n;
            done      <= done_n;
            remaining <= rem_n;
        end
    end

    // Next-state and next-output logic; bus drives hold their value until accepted.
    always_comb begin
        state_n = state;
        src_n   = src_ptr;
        dst_n   = dst_ptr;
        rem_n   = remaining;
        buf_n   = data_buf;
        addr_n  = addr_q;
        re_n    = re_q;
        we_n    = we_q;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_n   = aw'(src_addr >> 2);
                        dst_n   = aw'(dst_addr >> 2);
                        rem_n   = len;
                        addr_n  = aw'(src_addr >> 2);
                        re_n    = 1'b1;
                        state_n = RD;
                    end else begin
                        done_n  = 1'b1;
                        state_n = FIN;
                    end
                end
            end
            RD: begin
                if (bus.ready) begin
                    re_n    = 1'b0;
                    src_n   = src_ptr + aw'(1);
                    state_n = RWAIT;
                end
            end
            RWAIT: begin
                buf_n   = bus.rdata;
                addr_n  = dst_ptr;
                we_n    = 4'hF;
                state_n = WR;
            end
            WR: begin
                if (bus.ready) begin
                    we_n  = 4'h0;
                    dst_n = dst_ptr + aw'(1);
                    rem_n = remaining - len_bits'(1);
                    if (remaining == len_bits'(1)) begin
                        done_n  = 1'b1;
                        state_n = FIN;
                    end else begin
                        addr_n  = src_ptr;
                        re_n    = 1'b1;
                        state_n = RD;
                    end
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end
endmodule

// File: tb/tb_boa_dma_copy.sv
// Bench for boa_dma_copy: bus-side memory responder plus scoreboard of expected reads,
// writes and done pulses produced by a word-array copy model.
module tb_boa_dma_copy;
    localparam int unsigned LB = 16;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src_addr, dst_addr;
    logic [LB-1:0] len;
    logic          busy, done;
    logic [LB-1:0] remaining;

    boa_mem_bus #(.alen(30)) bus ();

    boa_dma_copy #(.len_bits(LB)) dut (
        .clk(clk), .rst(rst), .bus(bus), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0, passed = 0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Bus-side memory (written only by DUT writes) and the reference copy of it.
    logic [31:0] mem[logic [29:0]];
    logic [31:0] ref_mem[logic [29:0]];

    function automatic logic [31:0] seed_word(logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hC3A5_0000;
    endfunction
    function automatic logic [31:0] mem_rd(logic [29:0] a);
        return mem.exists(a) ? mem[a] : seed_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
    endfunction

    logic [29:0] exp_rd[$];
    wr_t         exp_wr[$];
    int          exp_done[$];
    int          start_cyc = 0;
    int          dones_seen = 0;
    int          done_base = 0;
    int          stall_rd_left = 0, stall_wr_left = 0;
    bit          rand_ready = 1'b0;

    bit          rd_pending = 1'b0;
    logic [29:0] rd_pend_addr;
    bit          hold_chk = 1'b0;
    logic [29:0] h_addr;
    logic        h_re;
    logic [3:0]  h_we;
    logic [31:0] h_wdata;

    // Memory responder and monitor: decide ready for the coming edge, score accepted accesses.
    always @(negedge clk) begin
        logic rdy;
        wr_t  e;
        int   lat;
        if (rst) begin
            rd_pending = 1'b0;
            hold_chk   = 1'b0;
            bus.ready  = 1'b1;
        end else begin
            bus.rdata  = rd_pending ? mem_rd(rd_pend_addr) : $urandom;
            rd_pending = 1'b0;
            if (hold_chk) begin
                chk("stall_addr_stable", bus.addr, h_addr);
                chk("stall_re_stable", bus.re, h_re);
                chk("stall_we_stable", bus.we, h_we);
                chk("stall_wdata_stable", bus.wdata, h_wdata);
            end
            if (bus.re && bus.we != 4'h0) chk("re_we_exclusive", {bus.re, bus.we}, 5'b10000);
            rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.re && stall_rd_left > 0) begin rdy = 1'b0; stall_rd_left--; end
            if (bus.we != 4'h0 && stall_wr_left > 0) begin rdy = 1'b0; stall_wr_left--; end
            bus.ready = rdy;
            hold_chk  = (bus.re || bus.we != 4'h0) && !rdy;
            h_addr = bus.addr; h_re = bus.re; h_we = bus.we; h_wdata = bus.wdata;
            if (bus.re && rdy) begin
                chk("read_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("read_addr", bus.addr, exp_rd.pop_front());
                rd_pending   = 1'b1;
                rd_pend_addr = bus.addr;
            end
            if (bus.we != 4'h0 && rdy) begin
                chk("write_expected", exp_wr.size() != 0, 1);
                chk("write_strobe", bus.we, 4'hF);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("write_addr", bus.addr, e.addr);
                    chk("write_data", bus.wdata, e.data);
                end
                mem[bus.addr] = bus.wdata;
            end
            if (done) begin
                dones_seen++;
                chk("done_expected", exp_done.size() != 0, 1);
                chk("busy_with_done", busy, 1);
                if (exp_done.size() != 0) begin
                    lat = exp_done.pop_front();
                    if (lat != 0) chk("done_latency", cyc - start_cyc + 1, lat);
                end
            end
        end
    end

    // Reference model: ascending word-by-word copy over the reference array.
    task automatic issue(logic [31:0] s, logic [31:0] d, logic [LB-1:0] n, int lat, bit completes);
        logic [29:0] sa, da;
        logic [31:0] w;
        for (int i = 0; i < int'(n); i++) begin
            sa = 30'((s >> 2) + 32'(i));
            da = 30'((d >> 2) + 32'(i));
            w  = ref_rd(sa);
            exp_rd.push_back(sa);
            exp_wr.push_back('{da, w});
            if (completes) ref_mem[da] = w;
        end
        if (completes) exp_done.push_back(lat);
        @(negedge clk);
        done_base = dones_seen;
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(posedge clk);
        #1 start_cyc = cyc;
        chk("busy_after_start", busy, 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            if (dones_seen > done_base) break;
        end
        if (k == budget) chk("done_timeout", dones_seen - done_base, 1);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_remaining", remaining, 0);
        chk("read_queue_drained", exp_rd.size(), 0);
        chk("write_queue_drained", exp_wr.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        bus.ready = 1'b1; bus.rdata = '0;
        for (int i = 0; i < 4; i++) begin
            mem[30'h40 + 30'(i)]     = 32'hA0 + 32'(i);
            ref_mem[30'h40 + 30'(i)] = 32'hA0 + 32'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_re", bus.re, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        @(negedge clk) rst = 1'b0;

        // Back-to-back copy of four words with ready high.
        issue(32'h100, 32'h200, 16'd4, 13, 1'b1);
        wait_done(200);
        for (int i = 0; i < 4; i++) chk("copy4_dst_word", mem_rd(30'h80 + 30'(i)), 32'hA0 + 32'(i));

        // Zero length: immediate done, no bus traffic.
        issue(32'h300, 32'h400, 16'd0, 1, 1'b1);
        wait_done(20);

        // Stalls of five cycles on both the read and the write.
        stall_rd_left = 5; stall_wr_left = 5;
        issue(32'h500, 32'h600, 16'd1, 14, 1'b1);
        wait_done(200);

        // A second start while busy must be ignored.
        issue(32'h700, 32'h800, 16'd3, 10, 1'b1);
        @(negedge clk);
        start = 1'b1; src_addr = 32'h900; dst_addr = 32'hA00; len = 16'd7;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (5) @(negedge clk);
        chk("no_extra_done", dones_seen - done_base, 1);

        // Asynchronous reset while a write is stalled.
        stall_wr_left = 1000;
        issue(32'hB00, 32'hC00, 16'd3, 0, 1'b0);
        for (k = 0; k < 100; k++) begin
            if (bus.we != 4'h0) break;
            @(negedge clk);
        end
        if (k == 100) chk("reach_wr_timeout", bus.we, 4'hF);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", bus.we, 0);
        chk("arst_re", bus.re, 0);
        chk("arst_busy", busy, 0);
        chk("arst_remaining", remaining, 0);
        exp_rd.delete(); exp_wr.delete(); exp_done.delete();
        stall_wr_left = 0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_done", done, 0);
        issue(32'hD00, 32'hE00, 16'd2, 7, 1'b1);
        wait_done(200);

        // Source pointer wraps from the top word address to zero.
        issue(32'hFFFF_FFFC, 32'h0000_0400, 16'd2, 7, 1'b1);
        wait_done(200);

        // Randomized, possibly overlapping copies under random ready.
        rand_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            issue(32'h1000 + ($urandom_range(0, 31) << 2), 32'h1000 + ($urandom_range(0, 31) << 2),
                  LB'($urandom_range(1, 8)), 0, 1'b1);
            wait_done(400);
        end
        rand_ready = 1'b0;
        for (int a = 32'h3F8; a < 32'h430; a++)
            chk("final_mem", mem_rd(30'(a)), ref_rd(30'(a)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
